// File: rtl/avl_mem_bridge.sv
// avl_mem_bridge: single-beat CPU load/store port to Avalon-MM master bridge.
// Request/ack handshake toward the core, byte enables, command held under
// waitrequest, out-of-range addresses rejected without a bus access.
// Optional bus watchdog enabled by defining AVL_MEM_BRIDGE_TIMEOUT_EN.
module avl_mem_bridge #(
    parameter int unsigned       ADDR_W      = 28,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       BE_W        = DATA_W / 8,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 28'hBBB3326,
    parameter int unsigned       TIMEOUT_CYC = 1024
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_be,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] avl_writedata,
    output logic [BE_W-1:0]   avl_byteenable,
    output logic              avl_burstcount,
    input  logic              avl_waitrequest,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;
    logic   next_err;
    logic   timeout_hit;

    // Single-beat transfers only.
    assign avl_burstcount = 1'b1;

`ifdef AVL_MEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wd_cnt;

    // Watchdog: counts cycles spent waiting on the bus, cleared otherwise.
    always_ff @(posedge iCLK) begin
        if (iRST || state == IDLE || state == DONE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
`endif

    // Next-state and completion status; bus acceptance wins over a
    // simultaneous watchdog expiry.
    always_comb begin
        next_state = state;
        next_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_addr > MAX_ADDR) begin
                        next_state = DONE;
                        next_err   = 1'b1;
                    end else if (cpu_we) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            WR: begin
                if (!avl_waitrequest) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state = DONE;
                    next_err   = 1'b1;
                end
            end
            RD: begin
                if (!avl_waitrequest) begin
                    next_state = RWAIT;
                end else if (timeout_hit) begin
                    next_state = DONE;
                    next_err   = 1'b1;
                end
            end
            RWAIT: begin
                if (avl_readdatavalid) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state = DONE;
                    next_err   = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and registered outputs; strobes are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state          <= IDLE;
            cpu_busy       <= 1'b0;
            cpu_ack        <= 1'b0;
            cpu_err        <= 1'b0;
            cpu_rdata      <= '0;
            avl_address    <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_writedata  <= '0;
            avl_byteenable <= '0;
        end else begin
            state     <= next_state;
            cpu_busy  <= (next_state != IDLE);
            cpu_ack   <= (next_state == DONE);
            cpu_err   <= next_err;
            avl_write <= (next_state == WR);
            avl_read  <= (next_state == RD);
            if (state == IDLE && cpu_req) begin
                avl_address    <= cpu_addr;
                avl_writedata  <= cpu_wdata;
                avl_byteenable <= cpu_be;
            end
            if (state == RWAIT && avl_readdatavalid) begin
                cpu_rdata <= avl_readdata;
            end
        end
    end

endmodule

// File: doc/avl_mem_bridge.md
Name: avl_mem_bridge

Overview:
- Parametrised successor to the single-beat CPU-to-Avalon-MM memory interface.
- Sits between the RV32I core's load/store port and the SDRAM/HPS Avalon-MM slave.
- Adds a request/acknowledge handshake, byte enables, explicit FSM command holding under waitrequest, and out-of-range error reporting.
- Supports an optional bus-timeout watchdog.

Parameters:
- ADDR_W, 28, word address width on the CPU and Avalon sides.
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width (derived).
- MAX_ADDR, 28'hBBB3326, highest legal word address; larger addresses are rejected.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- iCLK  in  1  clock.
- iRST  in  1  synchronous, active-high reset.
- cpu_req  in  1  transaction request; sampled only in IDLE.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_be  in  BE_W  byte enables.
- cpu_busy  out  1  high in any state except IDLE.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack; 1 = rejected or aborted.
- cpu_rdata  out  DATA_W  read data; updated only on a successful read completion.
- avl_address  out  ADDR_W  Avalon address.
- avl_read  out  1  Avalon read.
- avl_write  out  1  Avalon write.
- avl_writedata  out  DATA_W  Avalon write data.
- avl_byteenable  out  BE_W  Avalon byte enables.
- avl_burstcount  out  1  tied to 1.
- avl_waitrequest  in  1  slave stall.
- avl_readdatavalid  in  1  read data valid.
- avl_readdata  in  DATA_W  read data.

Behaviour:
- Reset values (iRST high at edge): state=IDLE; all outputs 0 except avl_burstcount=1; cpu_rdata=0.
- Reset mid-operation: avl_read/avl_write drop at the next edge with no ack. A late avl_readdatavalid is ignored.
- All outputs are registered.
- States: IDLE, WR, RD, RWAIT, DONE.
- IDLE, on cpu_req:
  - Latch cpu_addr, cpu_wdata, cpu_be and cpu_we into avl_address, avl_writedata and avl_byteenable.
  - If cpu_addr > MAX_ADDR: go to DONE with err=1 and no bus access.
  - Else if cpu_we: go to WR. Else: go to RD.
- WR: avl_write=1; address, data and byteenable held stable. An edge with avl_waitrequest=0 accepts the command; drop avl_write and go to DONE.
- RD: avl_read=1; address held stable. Acceptance as in WR; drop avl_read and go to RWAIT.
- RWAIT: on avl_readdatavalid, cpu_rdata<=avl_readdata and go to DONE.
- avl_readdatavalid in any state other than RWAIT is ignored.
- DONE: cpu_ack=1 (cpu_err as determined) for exactly one cycle, then IDLE.
  - cpu_req is not sampled in DONE.
  - A held cpu_req starts a new transaction in the IDLE cycle that follows.
- Latency with zero waitstates:
  - Write: req edge to ack = 2 cycles.
  - Read: 2 cycles + slave read latency.
  - Rejected request: ack 1 cycle after the req edge.
- Boundaries:
  - cpu_addr == MAX_ADDR is legal; MAX_ADDR+1 is rejected.
  - cpu_be=0 is still issued on the bus.
  - cpu_rdata holds its value across writes and errors.

Optional Feature:
- Macro: AVL_MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on IDLE and increments in WR, RD and RWAIT.
  - When it reaches TIMEOUT_CYC-1, the command is dropped and the FSM goes to DONE with cpu_err=1.
  - A late avl_readdatavalid after the abort is ignored.
- Undefined: no counter; WR, RD and RWAIT wait indefinitely; cpu_err is raised only for range violations.

Test Plan:
- Write 0x0000010 data 0xDEADBEEF be 0xF, waitrequest low → avl_write high for 1 cycle with matching address/data/byteenable; cpu_ack 2 cycles after req; cpu_err=0.
- Read 0x0000010, waitrequest high 3 cycles, readdatavalid 2 cycles after acceptance with 0xDEADBEEF → avl_read held 4 cycles with stable address; cpu_rdata=0xDEADBEEF; single ack, err=0.
- Read at MAX_ADDR+1 → no avl_read/avl_write; ack+err 1 cycle after req; cpu_rdata unchanged. The same request at MAX_ADDR → normal bus read.
- iRST asserted while in RWAIT, readdatavalid arrives 2 cycles later → outputs at reset values; no ack; cpu_rdata stays 0.
- With AVL_MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16, waitrequest stuck high on a write → avl_write drops after 16 cycles; ack with err=1. Without the macro, still busy at cycle 100.
